axis_frame_gen: RTL and testbench
=================================

// Module: axis_frame_gen
// PURPOSE
// - AXI4-Stream video frame transmitter. On a start pulse it emits one frame
//   of img_vsize lines x img_hsize pixels.
// - Framing: tuser marks start of frame (first pixel); tlast marks end of line.
// - Honours tready backpressure.
// - Inserts HBLANK idle cycles between lines.
// - Pulses frm_done when the final beat of the frame is accepted.
// - Drives the frame-complete/line-counting logic and the image pipeline in simulation and bring-up.
// PARAMETERS
// DATA_W   24  width of m_axis_tdata (pixel word)
// SIZE_W   12  width of img_hsize/img_vsize and internal x/y counters
// HBLANK    4  idle cycles (tvalid=0) after each line's tlast beat; 0 = back-to-back
// PORTS
// m_axis_aclk     in   1       clock
// m_axis_aresetn  in   1       async active-low reset
// start           in   1       1-cycle pulse: begin a frame (accepted only in IDLE)
// img_hsize       in   SIZE_W  pixels per line, sampled on accepted start
// img_vsize       in   SIZE_W  lines per frame, sampled on accepted start
// pattern_sel     in   2       0:x  1:y  2:x+y  3:fill_value; sampled on start
// fill_value      in   DATA_W  constant pixel for pattern 3, sampled on start
// m_axis_tdata    out  DATA_W  pixel data
// m_axis_tvalid   out  1       beat valid
// m_axis_tready   in   1       sink ready
// m_axis_tlast    out  1       last pixel of line
// m_axis_tuser    out  1       first pixel of frame (SOF)
// busy            out  1       high from accepted start until frm_done, inclusive
// frm_done        out  1       1-cycle pulse, cycle after the last beat's handshake
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - all outputs 0; state IDLE; x=y=0.
//   - Reset mid-frame aborts the frame immediately; no frm_done is generated.
// - States:
//   - IDLE: tvalid=0.
//     - start & hsize!=0 & vsize!=0 -> ACTIVE; latch sizes and pattern; x=y=0.
//     - start with a zero size is ignored; stay IDLE; no busy, no frm_done.
//   - ACTIVE: tvalid=1; beat completes on tvalid&tready.
//     - x == hsize-1 & y != vsize-1 -> GAP (or straight to ACTIVE, next line, if HBLANK=0).
//     - x == hsize-1 & y == vsize-1 -> DONE.
//   - GAP: tvalid=0 for exactly HBLANK cycles; then ACTIVE with x=0, y=y+1.
//   - DONE: single cycle; frm_done=1; busy=1; tvalid=0; next state IDLE.
// - First beat latency:
//   - tvalid rises the cycle after the accepted start (registered outputs).
//   - Each beat is valid in the cycle after the FSM enters ACTIVE.
// - AXI rules:
//   - While tvalid=1 & tready=0, tdata/tlast/tuser are held stable and tvalid stays 1.
//   - tready has no effect on tvalid deassertion timing other than stalling.
// - Framing:
//   - tuser=1 only on beat x=0,y=0.
//   - tlast=1 on every beat with x=hsize-1.
//   - hsize=1: every beat carries tlast; the first beat carries both tuser and tlast.
// - Pattern data:
//   - x, y and x+y are zero-extended to DATA_W; x+y is computed SIZE_W+1 wide.
//   - Results wider than DATA_W truncate to the LSBs.
// - Mid-frame inputs:
//   - start while busy is ignored.
//   - Changes to img_hsize/img_vsize/pattern_sel/fill_value mid-frame have no effect.
// - Max frame: hsize=vsize=2^SIZE_W-1. Counters never wrap within a legal frame.
// - Beats per frame = hsize*vsize exactly. Count of tlast beats = vsize. Count of tuser beats = 1.
// TESTING
// - Basic: hsize=4, vsize=3, pattern 0, tready=1.
//   -> 12 beats with tdata 0,1,2,3 per line;
//   -> tuser on beat 0; tlast on beats 3, 7 and 11;
//   -> 4 idle cycles between lines;
//   -> frm_done 1 cycle after beat 11.
// - Backpressure: hsize=3, vsize=2, pattern 2; tready random ~50%.
//   -> data sequence 0,1,2,1,2,3 unchanged;
//   -> outputs held stable while stalled;
//   -> exactly one frm_done.
// - Edge sizes: hsize=1, vsize=1, pattern 3, fill=24'hABCDEF.
//   -> one beat with tuser=tlast=1 and tdata=ABCDEF;
//   -> frm_done pulses 1 cycle later.
// - Zero/ignored starts:
//   - start with vsize=0 -> no tvalid, busy stays 0.
//   - start pulsed at beat 5 of a 4x3 frame -> frame unaffected; no second frame follows.
// - Reset mid-frame: assert aresetn=0 during line 2 of an 8x8 frame.
//   -> tvalid/tlast/tuser/busy drop to 0 asynchronously; no frm_done;
//   -> next start produces a clean frame beginning with tuser.
// - HBLANK=0 build: hsize=2, vsize=2, tready=1.
//   -> 4 consecutive valid beats with no gap; tlast on beats 1 and 3.

Source files
------------

// File: rtl/axis_frame_gen.sv
// AXI4-Stream video frame generator: one frame of img_vsize lines x img_hsize
// pixels per start pulse, with SOF on tuser, EOL on tlast and idle gaps between lines.
module axis_frame_gen #(
    parameter int DATA_W = 24,
    parameter int SIZE_W = 12,
    parameter int HBLANK = 4
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_aresetn,
    input  logic              start,
    input  logic [SIZE_W-1:0] img_hsize,
    input  logic [SIZE_W-1:0] img_vsize,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] fill_value,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              busy,
    output logic              frm_done
);

    localparam int CNT_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam logic [SIZE_W-1:0] ZERO = SIZE_W'(0);
    localparam logic [SIZE_W-1:0] ONE  = SIZE_W'(1);
    localparam logic [CNT_W-1:0]  LAST_BLANK = CNT_W'(HBLANK - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [SIZE_W-1:0]  x_r, x_s, y_r, y_s;
    logic [SIZE_W-1:0]  hmax_r, hmax_s, vmax_r, vmax_s;
    logic [1:0]         pat_r, pat_s;
    logic [DATA_W-1:0]  fill_r, fill_s;
    logic [CNT_W-1:0]   blank_cnt_r, blank_cnt_s;
    logic [DATA_W-1:0]  tdata_r, tdata_s;
    logic               tvalid_r, tvalid_s, tlast_r, tlast_s, tuser_r, tuser_s;
    logic               busy_r, busy_s, done_r, done_s;

    // x+y is formed one bit wider than the counters, then sized to the pixel word.
    function automatic logic [DATA_W-1:0] pixel_f(
        input logic [1:0]        sel,
        input logic [SIZE_W-1:0] x,
        input logic [SIZE_W-1:0] y,
        input logic [DATA_W-1:0] fill
    );
        logic [SIZE_W:0] sum_s;
        sum_s = {1'b0, x} + {1'b0, y};
        case (sel)
            2'd0:    pixel_f = DATA_W'(x);
            2'd1:    pixel_f = DATA_W'(y);
            2'd2:    pixel_f = DATA_W'(sum_s);
            2'd3:    pixel_f = fill;
            default: pixel_f = fill;
        endcase
    endfunction

    // Next-state and next-output logic; outputs are precomputed for the following cycle.
    always_comb begin
        state_s     = state_r;
        x_s         = x_r;
        y_s         = y_r;
        hmax_s      = hmax_r;
        vmax_s      = vmax_r;
        pat_s       = pat_r;
        fill_s      = fill_r;
        blank_cnt_s = blank_cnt_r;
        tdata_s     = tdata_r;
        tvalid_s    = 1'b0;
        tlast_s     = 1'b0;
        tuser_s     = 1'b0;
        busy_s      = busy_r;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (start && (img_hsize != ZERO) && (img_vsize != ZERO)) begin
                    state_s  = ST_ACTIVE;
                    x_s      = ZERO;
                    y_s      = ZERO;
                    hmax_s   = img_hsize - ONE;
                    vmax_s   = img_vsize - ONE;
                    pat_s    = pattern_sel;
                    fill_s   = fill_value;
                    tdata_s  = pixel_f(pattern_sel, ZERO, ZERO, fill_value);
                    tvalid_s = 1'b1;
                    tuser_s  = 1'b1;
                    tlast_s  = (img_hsize == ONE);
                    busy_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                busy_s = 1'b1;
                if (!m_axis_tready) begin
                    tvalid_s = 1'b1;
                    tlast_s  = tlast_r;
                    tuser_s  = tuser_r;
                end else if (x_r != hmax_r) begin
                    x_s      = x_r + ONE;
                    tdata_s  = pixel_f(pat_r, x_r + ONE, y_r, fill_r);
                    tvalid_s = 1'b1;
                    tlast_s  = ((x_r + ONE) == hmax_r);
                end else if (y_r == vmax_r) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else if (HBLANK == 0) begin
                    x_s      = ZERO;
                    y_s      = y_r + ONE;
                    tdata_s  = pixel_f(pat_r, ZERO, y_r + ONE, fill_r);
                    tvalid_s = 1'b1;
                    tlast_s  = (hmax_r == ZERO);
                end else begin
                    state_s     = ST_GAP;
                    blank_cnt_s = CNT_W'(0);
                end
            end
            ST_GAP: begin
                busy_s = 1'b1;
                if (blank_cnt_r == LAST_BLANK) begin
                    state_s  = ST_ACTIVE;
                    x_s      = ZERO;
                    y_s      = y_r + ONE;
                    tdata_s  = pixel_f(pat_r, ZERO, y_r + ONE, fill_r);
                    tvalid_s = 1'b1;
                    tlast_s  = (hmax_r == ZERO);
                end else begin
                    blank_cnt_s = blank_cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, latched frame parameters and registered AXIS outputs.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_r     <= ST_IDLE;
            x_r         <= ZERO;
            y_r         <= ZERO;
            hmax_r      <= ZERO;
            vmax_r      <= ZERO;
            pat_r       <= 2'd0;
            fill_r      <= {DATA_W{1'b0}};
            blank_cnt_r <= CNT_W'(0);
            tdata_r     <= {DATA_W{1'b0}};
            tvalid_r    <= 1'b0;
            tlast_r     <= 1'b0;
            tuser_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            y_r         <= y_s;
            hmax_r      <= hmax_s;
            vmax_r      <= vmax_s;
            pat_r       <= pat_s;
            fill_r      <= fill_s;
            blank_cnt_r <= blank_cnt_s;
            tdata_r     <= tdata_s;
            tvalid_r    <= tvalid_s;
            tlast_r     <= tlast_s;
            tuser_r     <= tuser_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tuser  = tuser_r;
    assign busy          = busy_r;
    assign frm_done      = done_r;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Bench for axis_frame_gen: default build (HBLANK=4) plus an HBLANK=0 build,
// checked beat by beat against a frame model built from the raster rules.
module tb_axis_frame_gen;

    localparam int HBLANK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sel_b = 1'b0;
    logic [11:0] img_hsize = 12'd0;
    logic [11:0] img_vsize = 12'd0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] fill_value = 24'd0;
    logic        tready = 1'b0;

    logic [23:0] a_tdata, b_tdata, o_tdata;
    logic        a_tvalid, a_tlast, a_tuser, a_busy, a_done;
    logic        b_tvalid, b_tlast, b_tuser, b_busy, b_done;
    logic        o_tvalid, o_tlast, o_tuser, o_busy, o_done;
    logic        start_a, start_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign start_a  = start & ~sel_b;
    assign start_b  = start & sel_b;
    assign o_tdata  = sel_b ? b_tdata  : a_tdata;
    assign o_tvalid = sel_b ? b_tvalid : a_tvalid;
    assign o_tlast  = sel_b ? b_tlast  : a_tlast;
    assign o_tuser  = sel_b ? b_tuser  : a_tuser;
    assign o_busy   = sel_b ? b_busy   : a_busy;
    assign o_done   = sel_b ? b_done   : a_done;

    axis_frame_gen #(.DATA_W(24), .SIZE_W(12), .HBLANK(HBLANK)) dut_a (
        .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .start(start_a),
        .img_hsize(img_hsize), .img_vsize(img_vsize), .pattern_sel(pattern_sel),
        .fill_value(fill_value), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid),
        .m_axis_tready(tready), .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser),
        .busy(a_busy), .frm_done(a_done)
    );

    axis_frame_gen #(.DATA_W(24), .SIZE_W(12), .HBLANK(0)) dut_b (
        .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .start(start_b),
        .img_hsize(img_hsize), .img_vsize(img_vsize), .pattern_sel(pattern_sel),
        .fill_value(fill_value), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
        .m_axis_tready(tready), .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
        .busy(b_busy), .frm_done(b_done)
    );

    // Runs one frame on the selected build and checks every cycle until frm_done.
    task automatic run_frame(input int h, input int v, input int pat, input logic [23:0] fill,
                             input int rdy_pct, input int inj_beat);
        logic [23:0] ed[$];
        bit          eu[$];
        bit          el[$];
        int          beat, cyc, done_cyc, gap, budget, exp_gap;
        bit          in_gap, prev_stall, injected, finished;
        logic [23:0] pd;
        logic        pl, pu;
        for (int y = 0; y < v; y++) begin
            for (int x = 0; x < h; x++) begin
                case (pat)
                    0:       ed.push_back(24'(x));
                    1:       ed.push_back(24'(y));
                    2:       ed.push_back(24'(x + y));
                    default: ed.push_back(fill);
                endcase
                eu.push_back(x == 0 && y == 0);
                el.push_back(x == h - 1);
            end
        end
        exp_gap = sel_b ? 0 : HBLANK;
        @(posedge clk); #1;
        img_hsize = 12'(h); img_vsize = 12'(v); pattern_sel = 2'(pat); fill_value = fill;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // scramble the frame inputs: the running frame must not notice
        img_hsize = 12'($urandom_range(1, 15)); img_vsize = 12'($urandom_range(1, 15));
        pattern_sel = 2'($urandom_range(3)); fill_value = 24'($urandom);
        beat = 0; cyc = 0; done_cyc = -1; gap = 0; in_gap = 0; prev_stall = 0;
        injected = 0; finished = 0; pd = 24'd0; pl = 1'b0; pu = 1'b0;
        budget = h * v * 30 + v * (HBLANK + 2) + 40;
        while (!finished && cyc < budget) begin
            tready = ($urandom_range(99) < rdy_pct);
            if (inj_beat >= 0 && !injected && beat >= inj_beat) begin
                start = 1'b1;
                injected = 1;
            end
            @(negedge clk);
            if (cyc == 0) begin
                vectors++;
                if (o_tvalid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL first_beat_latency: tvalid=%b, want 1", o_tvalid);
                end
            end
            if (prev_stall) begin
                vectors++;
                if (o_tvalid !== 1'b1 || o_tdata !== pd || o_tlast !== pl || o_tuser !== pu) begin
                    miscompares++;
                    $display("FAIL stall_hold cyc %0d: got v=%b d=%h l=%b u=%b, want v=1 d=%h l=%b u=%b",
                             cyc, o_tvalid, o_tdata, o_tlast, o_tuser, pd, pl, pu);
                end
            end
            if (done_cyc < 0 || cyc <= done_cyc) begin
                vectors++;
                if (o_busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy cyc %0d: got %b, want 1", cyc, o_busy);
                end
            end
            if (o_done === 1'b1) begin
                vectors++;
                if (cyc != done_cyc) begin
                    miscompares++;
                    $display("FAIL frm_done_timing: at cyc %0d, want cyc %0d", cyc, done_cyc);
                end
                finished = 1;
            end
            if (o_tvalid === 1'b1) begin
                if (in_gap) begin
                    vectors++;
                    if (gap != exp_gap) begin
                        miscompares++;
                        $display("FAIL hblank_gap: got %0d idle cycles, want %0d", gap, exp_gap);
                    end
                    in_gap = 0;
                end
                if (tready) begin
                    vectors++;
                    if (beat >= ed.size()) begin
                        miscompares++;
                        $display("FAIL extra_beat: beat %0d beyond frame of %0d", beat, ed.size());
                    end else begin
                        if (o_tdata !== ed[beat] || o_tuser !== eu[beat] || o_tlast !== el[beat]) begin
                            miscompares++;
                            $display("FAIL beat[%0d]: got d=%h u=%b l=%b, want d=%h u=%b l=%b",
                                     beat, o_tdata, o_tuser, o_tlast, ed[beat], eu[beat], el[beat]);
                        end
                        if (el[beat] && beat < h * v - 1) begin
                            in_gap = 1;
                            gap = 0;
                        end
                    end
                    beat++;
                    if (beat == h * v) done_cyc = cyc + 1;
                end
            end else if (in_gap) begin
                gap++;
            end else if (beat < h * v) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_idle cyc %0d: tvalid=0 at beat %0d", cyc, beat);
            end
            prev_stall = (o_tvalid === 1'b1) && !tready;
            pd = o_tdata; pl = o_tlast; pu = o_tuser;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL frame_timeout: no frm_done within %0d cycles (beats %0d)", budget, beat);
        end
        vectors++;
        if (beat != h * v) begin
            miscompares++;
            $display("FAIL beat_count: got %0d, want %0d", beat, h * v);
        end
        tready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            vectors++;
            if ({o_tvalid, o_busy, o_done} !== 3'b000) begin
                miscompares++;
                $display("FAIL post_frame_idle: v=%b busy=%b done=%b, want 000", o_tvalid, o_busy, o_done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({a_tvalid, a_tlast, a_tuser, a_busy, a_done, a_tdata} !== 29'd0 ||
            {b_tvalid, b_tlast, b_tuser, b_busy, b_done, b_tdata} !== 29'd0) begin
            miscompares++;
            $display("FAIL reset_state: a=%b%b%b%b%b/%h b=%b%b%b%b%b/%h, want all 0",
                     a_tvalid, a_tlast, a_tuser, a_busy, a_done, a_tdata,
                     b_tvalid, b_tlast, b_tuser, b_busy, b_done, b_tdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        sel_b = 1'b0;
        run_frame(4, 3, 0, 24'h0, 100, -1);
    endtask

    task automatic test_backpressure();
        sel_b = 1'b0;
        run_frame(3, 2, 2, 24'h0, 50, -1);
    endtask

    task automatic test_edge_sizes();
        sel_b = 1'b0;
        run_frame(1, 1, 3, 24'hABCDEF, 100, -1);
        run_frame(1, 3, 1, 24'h0, 60, -1);
    endtask

    task automatic test_zero_start();
        sel_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            img_hsize = (k == 0) ? 12'd5 : 12'd0;
            img_vsize = (k == 0) ? 12'd0 : 12'd3;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (8) begin
                @(negedge clk);
                vectors++;
                if ({a_tvalid, a_busy, a_done} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL zero_size_start[%0d]: v=%b busy=%b done=%b, want 000",
                             k, a_tvalid, a_busy, a_done);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        sel_b = 1'b0;
        run_frame(4, 3, 0, 24'h0, 100, 5);
    endtask

    task automatic test_reset_mid();
        sel_b = 1'b0;
        tready = 1'b1;
        @(posedge clk); #1;
        img_hsize = 12'd8; img_vsize = 12'd8; pattern_sel = 2'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        vectors++;
        if (a_tvalid !== 1'b1 || a_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_active: v=%b busy=%b, want 11", a_tvalid, a_busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({a_tvalid, a_tlast, a_tuser, a_busy, a_done} !== 5'b0) begin
            miscompares++;
            $display("FAIL async_reset_drop: v=%b l=%b u=%b busy=%b done=%b, want 00000",
                     a_tvalid, a_tlast, a_tuser, a_busy, a_done);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if ({a_tvalid, a_busy, a_done} !== 3'b000) begin
                miscompares++;
                $display("FAIL after_reset_idle: v=%b busy=%b done=%b, want 000", a_tvalid, a_busy, a_done);
            end
        end
        run_frame(8, 8, 1, 24'h0, 100, -1);
    endtask

    task automatic test_hblank0();
        sel_b = 1'b1;
        run_frame(2, 2, 0, 24'h0, 100, -1);
        run_frame(3, 3, 2, 24'h0, 50, -1);
        sel_b = 1'b0;
    endtask

    task automatic test_random();
        sel_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                      int'($urandom_range(3)), 24'($urandom), 60, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_edge_sizes();
        test_zero_start();
        test_start_while_busy();
        test_reset_mid();
        test_hblank0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
